// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB pipeline registers with a stalling, time-limited memory access FSM.
module mem_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [15:0] ex_alu_out,
    input  logic [15:0] ex_data_to_mem,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic [2:0]  ex_dst_reg,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        stall,
    output logic [15:0] EXMEM_DATA,
    output logic        EXMEM_RegWriteEN,
    output logic [2:0]  EXMEM_DstRegNum,
    output logic [15:0] WB_DATA,
    output logic        MEMWB_RegWriteEN,
    output logic [2:0]  MEMWB_DstRegNum,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
    localparam logic [3:0] TMO = 4'(TIMEOUT);
    state_t state, state_nx;
    logic [15:0] xm_data, xm_wdata, wb_data;
    logic        xm_rd, xm_wr, xm_rw, wb_rw;
    logic [2:0]  xm_dst, wb_dst;
    logic [3:0]  cnt;
    logic        is_mem, aligned, done_ok;
    assign is_mem  = xm_rd | xm_wr;
    assign aligned = ~xm_data[0];
    // mem_done only counts when a request is actually in flight
    assign done_ok = is_mem & mem_done & ((state == IDLE & aligned) | state == BUSY);
    assign mem_addr         = xm_data;
    assign mem_wdata        = xm_wdata;
    assign EXMEM_DATA       = xm_data;
    assign EXMEM_RegWriteEN = xm_rw;
    assign EXMEM_DstRegNum  = xm_dst;
    assign WB_DATA          = wb_data;
    assign MEMWB_RegWriteEN = wb_rw;
    assign MEMWB_DstRegNum  = wb_dst;
    assign err              = state == ERR;
    always_comb begin
        state_nx = state;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        stall    = 1'b0;
        unique case (state)
            IDLE: if (is_mem) begin
                stall    = ~done_ok;
                mem_rd   = xm_rd & aligned;
                mem_wr   = xm_wr & aligned;
                state_nx = !aligned ? ERR : mem_done ? IDLE : BUSY;
            end
            BUSY: begin
                stall    = ~mem_done;
                state_nx = mem_done ? IDLE : (cnt == TMO) ? ERR : BUSY;
            end
            ERR:     stall = 1'b1;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            xm_data  <= '0;
            xm_wdata <= '0;
            xm_rd    <= 1'b0;
            xm_wr    <= 1'b0;
            xm_rw    <= 1'b0;
            xm_dst   <= '0;
            wb_data  <= '0;
            wb_rw    <= 1'b0;
            wb_dst   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == BUSY) ? cnt + 4'd1 : 4'd0;
            if (!stall) begin
                xm_data  <= ex_valid ? ex_alu_out : 16'd0;
                xm_wdata <= ex_valid ? ex_data_to_mem : 16'd0;
                xm_rd    <= ex_valid & ex_mem_read;
                xm_wr    <= ex_valid & ex_mem_write;
                xm_rw    <= ex_valid & ex_reg_write & ~ex_mem_write;
                xm_dst   <= ex_valid ? ex_dst_reg : 3'd0;
            end
            wb_data <= stall ? 16'd0 : xm_rd ? mem_rdata : xm_data;
            wb_rw   <= ~stall & xm_rw;
            wb_dst  <= stall ? 3'd0 : xm_dst;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors; register write-backs are scoreboarded and checked by a separate monitor.
module tb_mem_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_reg_write = 1'b0;
    logic [15:0] ex_alu_out = '0, ex_data_to_mem = '0, mem_rdata = '0;
    logic [2:0]  ex_dst_reg = '0;
    logic        mem_done = 1'b0;
    logic [15:0] mem_addr, mem_wdata, EXMEM_DATA, WB_DATA;
    logic        mem_rd, mem_wr, stall, EXMEM_RegWriteEN, MEMWB_RegWriteEN, err;
    logic [2:0]  EXMEM_DstRegNum, MEMWB_DstRegNum;
    int tests = 0, fails = 0;
    logic [18:0] sb[$];

    mem_stage #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
        .ex_data_to_mem(ex_data_to_mem), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_dst_reg(ex_dst_reg), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .stall(stall), .EXMEM_DATA(EXMEM_DATA),
        .EXMEM_RegWriteEN(EXMEM_RegWriteEN), .EXMEM_DstRegNum(EXMEM_DstRegNum),
        .WB_DATA(WB_DATA), .MEMWB_RegWriteEN(MEMWB_RegWriteEN),
        .MEMWB_DstRegNum(MEMWB_DstRegNum), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ex;
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0;
        ex_alu_out = 0; ex_data_to_mem = 0; ex_dst_reg = 0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic rw,
                         input logic [15:0] a, input logic [15:0] d, input logic [2:0] dst);
        ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw;
        ex_alu_out = a; ex_data_to_mem = d; ex_dst_reg = dst;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_flags"}, {stall, err, mem_rd, mem_wr, EXMEM_RegWriteEN, MEMWB_RegWriteEN,
                               EXMEM_DstRegNum, MEMWB_DstRegNum}, 0);
        chk({name, "_data"}, {EXMEM_DATA, WB_DATA}, 0);
        chk({name, "_mem"}, {mem_addr, mem_wdata}, 0);
    endtask

    // monitor: every register write-back must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && MEMWB_RegWriteEN) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got %h/%0d expected no write", WB_DATA, MEMWB_DstRegNum);
            end else begin
                chk("sb_wb", {13'd0, WB_DATA, MEMWB_DstRegNum}, {13'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        step; step;
        @(negedge clk) chk_zero("reset");
        step; rst = 0;
        // single ALU op
        issue(0, 0, 1, 16'h1234, 16'h0, 3'd3); sb.push_back({16'h1234, 3'd3});
        step; idle_ex;
        @(negedge clk);
        chk("alu_exmem", {EXMEM_DATA, EXMEM_RegWriteEN, EXMEM_DstRegNum}, {16'h1234, 1'b1, 3'd3});
        chk("alu_stall", stall, 0);
        step; chk("alu_stall2", stall, 0);
        step;
        // back-to-back ALU ops, last one without register write
        issue(0, 0, 1, 16'h0001, 16'h0, 3'd1); sb.push_back({16'h0001, 3'd1});
        step; issue(0, 0, 1, 16'hFFFF, 16'h0, 3'd7); sb.push_back({16'hFFFF, 3'd7});
        step; issue(0, 0, 0, 16'h5555, 16'h0, 3'd4);
        @(negedge clk) chk("b2b_exmem", {EXMEM_DATA, EXMEM_DstRegNum, stall}, {16'hFFFF, 3'd7, 1'b0});
        step; idle_ex;
        @(negedge clk) chk("b2b_norw", {EXMEM_DATA, EXMEM_RegWriteEN}, {16'h5555, 1'b0});
        step; step;
        // stray mem_done with nothing outstanding
        mem_done = 1;
        @(negedge clk) chk("spur_done", {stall, mem_rd, mem_wr}, 0);
        step; mem_done = 0;
        @(negedge clk) chk("spur_err", {err, stall}, 0);
        // load with mem_done three cycles after mem_rd
        issue(1, 0, 1, 16'h0040, 16'h0, 3'd5); sb.push_back({16'hBEEF, 3'd5});
        step; idle_ex;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_done = 1; mem_rdata = 16'hBEEF; end
            @(negedge clk);
            chk("ld_stall", stall, i < 3);
            chk("ld_rd", mem_rd, i == 0);
            chk("ld_addr", mem_addr, 16'h0040);
            step;
        end
        mem_done = 0; mem_rdata = 0;
        step;
        // store completing in the request cycle
        issue(0, 1, 1, 16'h0010, 16'h00AA, 3'd2);
        step; idle_ex; mem_done = 1;
        @(negedge clk) chk("st_req", {mem_wr, mem_rd, stall, mem_addr, mem_wdata}, {3'b100, 16'h0010, 16'h00AA});
        step; mem_done = 0;
        @(negedge clk) chk("st_wb", {MEMWB_RegWriteEN, stall}, 0);
        step;
        // completion on the same cycle the wait counter reaches TIMEOUT
        issue(1, 0, 1, 16'h0100, 16'h0, 3'd6); sb.push_back({16'hCAFE, 3'd6});
        step; idle_ex;
        for (int i = 0; i <= 16; i++) begin
            if (i == 16) begin mem_done = 1; mem_rdata = 16'hCAFE; end
            @(negedge clk) chk("prio_stall", stall, i < 16);
            step;
        end
        mem_done = 0; mem_rdata = 0;
        @(negedge clk) chk("prio_no_err", err, 0);
        step;
        // load that never completes
        issue(1, 0, 1, 16'h0080, 16'h0, 3'd4);
        step; idle_ex;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i <= 15 || i >= 17) chk("tmo_err", err, i >= 17);
            chk("tmo_rd", mem_rd, i == 0);
            if (i >= 17) chk("tmo_stall", stall, 1);
            step;
        end
        rst = 1; step;
        @(negedge clk) chk_zero("tmo_rst");
        step; rst = 0;
        // misaligned load
        issue(1, 0, 1, 16'h0041, 16'h0, 3'd1);
        step; idle_ex;
        @(negedge clk) chk("mis_rd", {mem_rd, mem_wr, err}, 0);
        for (int i = 0; i < 4; i++) begin
            step;
            @(negedge clk) chk("mis_err", {err, stall, mem_rd, MEMWB_RegWriteEN}, 4'b1100);
        end
        step; rst = 1; step;
        @(negedge clk) chk_zero("mis_rst");
        step; rst = 0;
        // reset while BUSY
        issue(1, 0, 1, 16'h0200, 16'h0, 3'd2);
        step; idle_ex;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) chk("rb_stall", stall, 1);
            step;
        end
        rst = 1; step; rst = 0;
        @(negedge clk) chk_zero("rb_after");
        step;
        @(negedge clk) chk("rb_idle", {mem_rd, mem_wr, stall, err}, 0);
        issue(0, 0, 1, 16'h0ABC, 16'h0, 3'd2); sb.push_back({16'h0ABC, 3'd2});
        step; idle_ex; step; step; step;
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum cycles to wait for mem_done before flagging err.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ex_valid, input, 1: the EX stage presents a valid instruction.
REQ-005 SHALL have port ex_alu_out, input, 16: ALU result, also the memory address.
REQ-006 SHALL have port ex_data_to_mem, input, 16: forwarded store data.
REQ-007 SHALL have ports ex_mem_read and ex_mem_write, input, 1 each: load and store requests, mutually exclusive.
REQ-008 SHALL have port ex_reg_write, input, 1: the instruction writes the register file.
REQ-009 SHALL have port ex_dst_reg, input, 3: destination register number.
REQ-010 SHALL have port mem_addr, output, 16: memory address.
REQ-011 SHALL have port mem_wdata, output, 16: memory write data.
REQ-012 SHALL have ports mem_rd and mem_wr, output, 1 each: memory request strobes.
REQ-013 SHALL have port mem_rdata, input, 16: memory read data.
REQ-014 SHALL have port mem_done, input, 1: the memory access is complete this cycle.
REQ-015 SHALL have port stall, output, 1: freezes IF, ID and EX, and holds the EX outputs stable.
REQ-016 SHALL have ports EXMEM_DATA (16), EXMEM_RegWriteEN (1) and EXMEM_DstRegNum (3), outputs: forwarding sources from the EX/MEM register.
REQ-017 SHALL have ports WB_DATA (16), MEMWB_RegWriteEN (1) and MEMWB_DstRegNum (3), outputs: write-back and forwarding sources from the MEM/WB register.
REQ-018 SHALL have port err, output, 1: sticky error flag.

Function
REQ-019 SHALL capture the ex_* inputs into the EX/MEM register on every rising edge where stall=0; ex_valid=0 SHALL load a bubble (all enables 0).
REQ-020 SHALL drive EXMEM_DATA, EXMEM_RegWriteEN and EXMEM_DstRegNum directly from the EX/MEM register, with zero combinational delay from the register.
REQ-021 SHALL implement an FSM with states IDLE, BUSY and ERR.
REQ-022 In IDLE, if EX/MEM holds a load or store and address bit 0 is 0, the block SHALL assert mem_rd or mem_wr for exactly one cycle.
REQ-023 In that same cycle the block SHALL drive mem_addr=EX/MEM address and mem_wdata=EX/MEM store data, and SHALL go to BUSY unless mem_done=1 in the same cycle.
REQ-024 In BUSY the block SHALL hold mem_addr and mem_wdata, deassert mem_rd and mem_wr, and return to IDLE on the cycle mem_done=1.
REQ-025 stall SHALL be 1 whenever a memory op is in EX/MEM and mem_done has not yet been seen; it SHALL be 0 in the cycle mem_done=1.
REQ-026 Non-memory instructions SHALL never stall.
REQ-027 On a memory op completion, or on any non-memory instruction, the MEM/WB register SHALL capture on the next edge.
REQ-028 MEM/WB SHALL capture WB_DATA=mem_rdata for loads and WB_DATA=EX/MEM data otherwise, together with EX/MEM RegWriteEN and DstRegNum.
REQ-029 While stall=1, MEM/WB SHALL load a bubble (MEMWB_RegWriteEN=0, WB_DATA=0, MEMWB_DstRegNum=0).
REQ-030 Stores SHALL forward a captured RegWriteEN of 0 regardless of ex_reg_write.
REQ-031 A 4-bit wait counter SHALL clear on IDLE->BUSY and increment each BUSY cycle.
REQ-032 When the wait counter equals TIMEOUT with mem_done still 0, the block SHALL go to ERR.
REQ-033 A memory op with address bit 0 = 1 SHALL issue no request and SHALL go to ERR on the next edge.
REQ-034 ERR SHALL be terminal until rst.
REQ-035 In ERR: err=1, stall=1, mem_rd=mem_wr=0, and MEM/WB loads bubbles.
REQ-036 When mem_done=1 in the same cycle the counter reaches TIMEOUT, completion SHALL take priority over ERR.
REQ-037 mem_done asserted in IDLE with no request outstanding SHALL be ignored.

Reset
REQ-038 On rst=1 at a clock edge: FSM->IDLE, counter=0, EX/MEM and MEM/WB cleared to bubbles, err=0.
REQ-039 Reset SHALL override every other event, including a mid-access BUSY; the outstanding request is abandoned and mem_rd=mem_wr=0 the cycle after reset.
REQ-040 All outputs SHALL be 0 while in reset.

Verification
REQ-041 ALU op with ex_alu_out=0x1234, ex_reg_write=1, ex_dst_reg=3 -> next cycle EXMEM_DATA=0x1234, EXMEM_DstRegNum=3; one cycle later WB_DATA=0x1234, MEMWB_RegWriteEN=1; stall never asserts.
REQ-042 Load from 0x0040 with mem_done returned 3 cycles after mem_rd and mem_rdata=0xBEEF -> stall=1 for 3 cycles, mem_rd high one cycle only, then WB_DATA=0xBEEF with MEMWB_RegWriteEN=1.
REQ-043 Store of 0x00AA to 0x0010 with mem_done in the same cycle as mem_wr -> no stall; MEMWB_RegWriteEN=0.
REQ-044 Load from 0x0041 -> no mem_rd; err=1 and stall=1 from the next cycle; both hold until rst.
REQ-045 Load with mem_done never asserted -> err=1 after 15 BUSY cycles; rst asserted mid-BUSY in a separate run -> IDLE next cycle with all outputs 0.
